// File: rtl/dma_cmd_sequencer_if.sv
// Signal bundle between the GPIO/shim side and dma_cmd_sequencer.
// master drives commands and the shim done pulse; slave is the sequencer.
interface dma_cmd_sequencer_if #(
  parameter int unsigned FIFO_AW = 2
);
  logic              cmd_push;
  logic              cmd_dir;
  logic [31:0]       cmd_addr;
  logic [29:0]       cmd_len;
  logic              seq_enable;
  logic              status_clr;
  logic              dma_start_transfer;
  logic              dma_direction;
  logic [31:0]       dma_ddr_addr;
  logic [29:0]       dma_length_bytes;
  logic              dma_transfer_done;
  logic              busy;
  logic [FIFO_AW:0]  fifo_count;
  logic [15:0]       done_count;
  logic              overflow_err;
  logic              spurious_err;
  logic              timeout_err;

  modport master (
    output cmd_push, cmd_dir, cmd_addr, cmd_len, seq_enable, status_clr, dma_transfer_done,
    input  dma_start_transfer, dma_direction, dma_ddr_addr, dma_length_bytes,
           busy, fifo_count, done_count, overflow_err, spurious_err, timeout_err
  );

  modport slave (
    input  cmd_push, cmd_dir, cmd_addr, cmd_len, seq_enable, status_clr, dma_transfer_done,
    output dma_start_transfer, dma_direction, dma_ddr_addr, dma_length_bytes,
           busy, fifo_count, done_count, overflow_err, spurious_err, timeout_err
  );
endinterface

// File: rtl/dma_cmd_sequencer.sv
// Queues GPIO DMA commands and issues them one at a time to the AXI DMA shim.
// Optional watchdog in WAIT_DONE enabled by defining DMA_SEQ_TIMEOUT_EN.
module dma_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned FIFO_AW        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16777216
) (
  input logic                clk,
  input logic                reset,
  dma_cmd_sequencer_if.slave bus
);

  localparam int unsigned CmdW = 63;
  localparam logic [FIFO_AW:0] Full = (FIFO_AW + 1)'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH != (1 << FIFO_AW)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2 matching FIFO_AW");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 16777216) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 24-bit watchdog");
  end

  typedef enum logic {StIdle, StWaitDone} state_e;

  state_e               state_q;
  logic [CmdW-1:0]      mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]     count_q;
  logic                 push_q, clr_q;
  logic                 start_q, dir_q;
  logic [31:0]          addr_q;
  logic [29:0]          len_q;
  logic [15:0]          done_cnt_q;
  logic                 ovf_q, spur_q, tout_q;
  logic                 push_evt, clr_evt, pop, push_ok, halt;
  logic [CmdW-1:0]      head;

`ifdef DMA_SEQ_TIMEOUT_EN
  localparam logic [23:0] WdLast = 24'(TIMEOUT_CYCLES - 1);
  logic [23:0] wd_cnt_q;
  assign halt = tout_q;
`else
  assign halt = 1'b0;
`endif

  always_comb begin
    push_evt = bus.cmd_push & ~push_q;
    clr_evt  = bus.status_clr & ~clr_q;
    pop      = (state_q == StIdle) & bus.seq_enable & (count_q != '0) & ~halt;
    // A pop frees the head slot on this edge, so a push at full still fits.
    push_ok  = push_evt & ((count_q < Full) | pop);
    head     = mem[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= {bus.cmd_dir, bus.cmd_addr, bus.cmd_len};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      push_q     <= 1'b0;
      clr_q      <= 1'b0;
      start_q    <= 1'b0;
      dir_q      <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      done_cnt_q <= '0;
      ovf_q      <= 1'b0;
      spur_q     <= 1'b0;
      tout_q     <= 1'b0;
`ifdef DMA_SEQ_TIMEOUT_EN
      wd_cnt_q   <= '0;
`endif
    end else begin
      push_q  <= bus.cmd_push;
      clr_q   <= bus.status_clr;
      start_q <= 1'b0;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop) count_q <= count_q - 1'b1;

      // Sets take priority over a simultaneous clear.
      ovf_q  <= (push_evt & ~push_ok) | (ovf_q & ~clr_evt);
      spur_q <= (bus.dma_transfer_done & (state_q != StWaitDone)) | (spur_q & ~clr_evt);
      tout_q <= tout_q & ~clr_evt;

      unique case (state_q)
        StIdle: begin
          if (pop) begin
            dir_q   <= head[62];
            addr_q  <= head[61:30];
            len_q   <= head[29:0];
            start_q <= 1'b1;
            state_q <= StWaitDone;
`ifdef DMA_SEQ_TIMEOUT_EN
            wd_cnt_q <= '0;
`endif
          end
        end
        StWaitDone: begin
          if (bus.dma_transfer_done) begin
            done_cnt_q <= done_cnt_q + 16'd1;
            state_q    <= StIdle;
`ifdef DMA_SEQ_TIMEOUT_EN
          end else if (wd_cnt_q == WdLast) begin
            tout_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            wd_cnt_q <= wd_cnt_q + 24'd1;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.dma_start_transfer = start_q;
  assign bus.dma_direction      = dir_q;
  assign bus.dma_ddr_addr       = addr_q;
  assign bus.dma_length_bytes   = len_q;
  assign bus.busy               = (state_q == StWaitDone);
  assign bus.fifo_count         = count_q;
  assign bus.done_count         = done_cnt_q;
  assign bus.overflow_err       = ovf_q;
  assign bus.spurious_err       = spur_q;
  assign bus.timeout_err        = tout_q;

endmodule

// File: tb/tb_dma_cmd_sequencer.sv
// Bench for dma_cmd_sequencer: directed scenarios plus random traffic, every cycle
// compared against a queue-based transaction model of the sequencer.
module tb_dma_cmd_sequencer;

  localparam int unsigned Depth = 4;
`ifdef DMA_SEQ_TIMEOUT_EN
  localparam int unsigned ToCycles = 64;
`else
  localparam int unsigned ToCycles = 16777216;
`endif

  typedef struct packed {
    logic        dir;
    logic [31:0] addr;
    logic [29:0] len;
  } cmd_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dma_cmd_sequencer_if #(.FIFO_AW(2)) bus ();

  dma_cmd_sequencer #(
    .FIFO_DEPTH    (Depth),
    .FIFO_AW       (2),
    .TIMEOUT_CYCLES(ToCycles)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad = 0;

  // Reference model state (values expected after the most recent edge).
  cmd_t mq[$];
  logic m_busy, m_start, m_dir, m_ovf, m_spur, m_tout, m_push_prev, m_clr_prev;
  logic [31:0] m_addr;
  logic [29:0] m_len;
  int m_dcnt, m_wcnt;

  int shim_delay = 5;   // -1: shim never answers
  int done_wait = -1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 0; m_start = 0; m_dir = 0; m_addr = '0; m_len = '0;
    m_ovf = 0; m_spur = 0; m_tout = 0; m_push_prev = 0; m_clr_prev = 0;
    m_dcnt = 0; m_wcnt = 0;
  endtask

  task automatic model_edge();
    logic pe, ce, pop, acc, s_ovf, s_spur, s_to;
    cmd_t c;
    if (reset) return;
    pe = bus.cmd_push && !m_push_prev;
    ce = bus.status_clr && !m_clr_prev;
    m_push_prev = bus.cmd_push;
    m_clr_prev = bus.status_clr;
    s_ovf = 0; s_spur = 0; s_to = 0;
    m_start = 0;
    pop = !m_busy && bus.seq_enable && mq.size() > 0 && !m_tout;
    if (m_busy) begin
      if (bus.dma_transfer_done) begin
        m_busy = 0;
        m_dcnt = (m_dcnt + 1) % 65536;
      end
`ifdef DMA_SEQ_TIMEOUT_EN
      else if (m_wcnt == ToCycles - 1) begin
        s_to = 1;
        m_busy = 0;
      end else m_wcnt++;
`endif
    end else if (bus.dma_transfer_done) s_spur = 1;
    acc = pe && (mq.size() < Depth || pop);
    if (pe && !acc) s_ovf = 1;
    if (pop) begin
      c = mq.pop_front();
      m_dir = c.dir; m_addr = c.addr; m_len = c.len;
      m_start = 1; m_busy = 1; m_wcnt = 0;
      if (shim_delay >= 0) done_wait = shim_delay;
    end
    if (acc) mq.push_back({bus.cmd_dir, bus.cmd_addr, bus.cmd_len});
    if (ce) begin m_ovf = 0; m_spur = 0; m_tout = 0; end
    if (s_ovf) m_ovf = 1;
    if (s_spur) m_spur = 1;
    if (s_to) m_tout = 1;
  endtask

  task automatic compare_all();
    check_eq("start", bus.dma_start_transfer, m_start);
    check_eq("dir", bus.dma_direction, m_dir);
    check_eq("addr", bus.dma_ddr_addr, m_addr);
    check_eq("len", bus.dma_length_bytes, m_len);
    check_eq("busy", bus.busy, m_busy);
    check_eq("fifo_count", bus.fifo_count, mq.size());
    check_eq("done_count", bus.done_count, m_dcnt);
    check_eq("overflow_err", bus.overflow_err, m_ovf);
    check_eq("spurious_err", bus.spurious_err, m_spur);
    check_eq("timeout_err", bus.timeout_err, m_tout);
  endtask

  // One clock: update model at the edge, compare 1 time unit later, then drive shim done.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    bus.dma_transfer_done = 1'b0;
    if (done_wait == 0) begin
      bus.dma_transfer_done = 1'b1;
      done_wait = -1;
    end else if (done_wait > 0) done_wait--;
  endtask

  task automatic push_cmd(input logic dir, input logic [31:0] addr, input logic [29:0] len);
    bus.cmd_dir = dir; bus.cmd_addr = addr; bus.cmd_len = len;
    bus.cmd_push = 1'b1;
    tick();
    bus.cmd_push = 1'b0;
    tick();
  endtask

  task automatic clear_status();
    bus.status_clr = 1'b1;
    tick();
    bus.status_clr = 1'b0;
    tick();
  endtask

  initial begin
    bus.cmd_push = 0; bus.cmd_dir = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.seq_enable = 0; bus.status_clr = 0; bus.dma_transfer_done = 0;
    model_reset();
    repeat (2) tick();
    reset = 1'b0;

    // Single command, shim answers 20 cycles after start.
    bus.seq_enable = 1;
    shim_delay = 20;
    push_cmd(1'b1, 32'h1000_0000, 30'h400);
    repeat (30) tick();

    // Overfill with sequencing disabled, then drain in order.
    bus.seq_enable = 0;
    for (int i = 0; i < 5; i++) push_cmd(i[0], 32'h2000_0000 + 32'(i * 256), 30'(64 + i));
    bus.seq_enable = 1;
    shim_delay = 10;
    repeat (60) tick();
    clear_status();

    // Push at full in the same cycle as a pop.
    bus.seq_enable = 0;
    for (int i = 0; i < 4; i++) push_cmd(1'b0, 32'h3000_0000 + 32'(i), 30'(i + 1));
    bus.seq_enable = 1;
    bus.cmd_dir = 1; bus.cmd_addr = 32'h3000_00AA; bus.cmd_len = 30'h55;
    bus.cmd_push = 1;
    shim_delay = 5;
    tick();
    bus.cmd_push = 0;
    repeat (50) tick();

    // Spurious done in idle, then a long-held push.
    bus.dma_transfer_done = 1;
    tick();
    repeat (2) tick();
    clear_status();
    bus.seq_enable = 0;
    bus.cmd_dir = 0; bus.cmd_addr = 32'h4000_0000; bus.cmd_len = 30'h10;
    bus.cmd_push = 1;
    repeat (10) tick();
    bus.cmd_push = 0;
    bus.seq_enable = 1;
    repeat (15) tick();

    // Reset while a transfer is outstanding with two commands still queued.
    bus.seq_enable = 0;
    for (int i = 0; i < 3; i++) push_cmd(1'b1, 32'h5000_0000 + 32'(i * 16), 30'(200 + i));
    shim_delay = -1;
    bus.seq_enable = 1;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    done_wait = -1;
    compare_all();
    repeat (2) tick();
    reset = 1'b0;
    bus.dma_transfer_done = 1;
    tick();
    repeat (2) tick();
    clear_status();

`ifdef DMA_SEQ_TIMEOUT_EN
    // Watchdog: no done, second command held back until the error is cleared.
    bus.seq_enable = 0;
    push_cmd(1'b1, 32'h6000_0000, 30'h80);
    push_cmd(1'b0, 32'h6000_1000, 30'h90);
    bus.seq_enable = 1;
    shim_delay = -1;
    repeat (80) tick();
    shim_delay = 3;
    clear_status();
    repeat (20) tick();
`endif

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      shim_delay = $urandom_range(0, 8);
      if ($urandom_range(0, 3) == 0) bus.cmd_push = ~bus.cmd_push;
      bus.cmd_dir  = 1'($urandom);
      bus.cmd_addr = $urandom;
      bus.cmd_len  = 30'($urandom);
      bus.seq_enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) bus.status_clr = ~bus.status_clr;
      if (done_wait < 0 && !m_busy && $urandom_range(0, 24) == 0) bus.dma_transfer_done = 1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
